// File: rtl/fir_pkg.sv
// Shared definitions for the fir dot-product engine.
//   - default sample/coefficient width and tap count
//   - width helpers for the product and accumulator
//   - slice_elem: extracts element idx of width elem_w from a packed vector
package fir_pkg;

    localparam int DEF_NUMBER_SIZE = 16;
    localparam int DEF_NUM_COEFF   = 4;

    localparam int PROD_W = 2 * DEF_NUMBER_SIZE;
    localparam int ACC_W  = PROD_W + $clog2(DEF_NUM_COEFF);

    // Widest packed vector / element the slice helper handles.
    localparam int MAX_VEC_W  = 1024;
    localparam int MAX_ELEM_W = 64;

    function automatic int prod_width(input int number_size);
        return 2 * number_size;
    endfunction

    function automatic int acc_width(input int number_size, input int num_coeff);
        return 2 * number_size + $clog2(num_coeff);
    endfunction

    // Returns element idx (elem_w bits, zero-extended) of a packed vector.
    function automatic logic [MAX_ELEM_W-1:0] slice_elem(
        input logic [MAX_VEC_W-1:0] vec,
        input int unsigned          idx,
        input int unsigned          elem_w
    );
        logic [MAX_VEC_W-1:0]  shifted;
        logic [MAX_ELEM_W-1:0] res;
        shifted = vec >> (idx * elem_w);
        res     = '0;
        for (int b = 0; b < MAX_ELEM_W; b++) begin
            if (b < int'(elem_w)) begin
                res[b] = shifted[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_tap.sv
// One FIR tap: signed NUMBER_SIZE x NUMBER_SIZE multiply with a registered
// full-precision product.
// Ports:
//   clk, rst (sync, active-high), ena (advance)
//   x, c   : signed sample and coefficient
//   p      : registered 2*NUMBER_SIZE-bit product
module fir_tap
    import fir_pkg::*;
#(
    parameter int NUMBER_SIZE = DEF_NUMBER_SIZE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [NUMBER_SIZE-1:0]         x,
    input  logic [NUMBER_SIZE-1:0]         c,
    output logic [2*NUMBER_SIZE-1:0]       p
);

    localparam int TAP_PROD_W = 2 * NUMBER_SIZE;

    logic signed [TAP_PROD_W-1:0] x_ext;
    logic signed [TAP_PROD_W-1:0] c_ext;
    logic        [TAP_PROD_W-1:0] p_d;
    logic        [TAP_PROD_W-1:0] p_q;

    // Sign-extend both operands to the product width first so the low
    // TAP_PROD_W bits of the multiply are the exact signed product, including
    // most-negative x most-negative.
    always_comb begin
        x_ext = TAP_PROD_W'($signed(x));
        c_ext = TAP_PROD_W'($signed(c));
        p_d   = p_q;
        if (ena) begin
            p_d = x_ext * c_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/fir.sv
// Direct-form FIR dot-product engine: y_n = low NUMBER_SIZE bits of sum(x_i*c_i).
// Stage 1: per-tap product registers (fir_tap) plus a valid bit.
// Stage 2: accumulated, wrap-truncated sum into y_n and valid into y_valid.
// Ports:
//   clk, rst (sync, active-high, priority over ena), ena (advance both stages)
//   x_ns, coeffs : packed signed samples / coefficients, element i at
//                  [(i+1)*NUMBER_SIZE-1 : i*NUMBER_SIZE]
//   y_n, y_valid : registered result and its valid flag
module fir
    import fir_pkg::*;
#(
    parameter int NUMBER_SIZE = DEF_NUMBER_SIZE,
    parameter int NUM_COEFF   = DEF_NUM_COEFF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic [NUM_COEFF*NUMBER_SIZE-1:0] x_ns,
    input  logic [NUM_COEFF*NUMBER_SIZE-1:0] coeffs,
    output logic [NUMBER_SIZE-1:0]           y_n,
    output logic                             y_valid
);

    localparam int P_W = prod_width(NUMBER_SIZE);
    localparam int A_W = acc_width(NUMBER_SIZE, NUM_COEFF);

    logic [MAX_VEC_W-1:0] x_ext;
    logic [MAX_VEC_W-1:0] c_ext;

    assign x_ext = MAX_VEC_W'(x_ns);
    assign c_ext = MAX_VEC_W'(coeffs);

    logic [P_W-1:0] prod [NUM_COEFF];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COEFF; gi++) begin : g_tap
            logic [NUMBER_SIZE-1:0] x_i;
            logic [NUMBER_SIZE-1:0] c_i;
            assign x_i = NUMBER_SIZE'(slice_elem(x_ext, gi, NUMBER_SIZE));
            assign c_i = NUMBER_SIZE'(slice_elem(c_ext, gi, NUMBER_SIZE));

            fir_tap #(
                .NUMBER_SIZE (NUMBER_SIZE)
            ) u_tap (
                .clk (clk),
                .rst (rst),
                .ena (ena),
                .x   (x_i),
                .c   (c_i),
                .p   (prod[gi])
            );
        end
    endgenerate

    logic signed [A_W-1:0]  acc_sum;
    logic                   valid1_d;
    logic                   valid1_q;
    logic [NUMBER_SIZE-1:0] y_n_d;
    logic [NUMBER_SIZE-1:0] y_n_q;
    logic                   y_valid_d;
    logic                   y_valid_q;

    // The accumulator is wide enough that no partial sum overflows; only the
    // final truncation to NUMBER_SIZE wraps.
    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < NUM_COEFF; i++) begin
            acc_sum = acc_sum + A_W'($signed(prod[i]));
        end
    end

    always_comb begin
        valid1_d  = valid1_q;
        y_n_d     = y_n_q;
        y_valid_d = y_valid_q;
        if (ena) begin
            valid1_d  = 1'b1;
            y_n_d     = acc_sum[NUMBER_SIZE-1:0];
            y_valid_d = valid1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q  <= 1'b0;
            y_n_q     <= '0;
            y_valid_q <= 1'b0;
        end else begin
            valid1_q  <= valid1_d;
            y_n_q     <= y_n_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y_n     = y_n_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_fir.sv
module tb_fir;

    localparam int NS = 16;
    localparam int NC = 4;

    logic              clk;
    logic              rst;
    logic              ena;
    logic [NC*NS-1:0]  x_ns;
    logic [NC*NS-1:0]  coeffs;
    logic [NS-1:0]     y_n;
    logic              y_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: list of results of every enabled edge since reset.
    logic [NS-1:0] hist[$];
    logic [NS-1:0] exp_y;
    logic          exp_v;

    fir #(
        .NUMBER_SIZE (NS),
        .NUM_COEFF   (NC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .x_ns    (x_ns),
        .coeffs  (coeffs),
        .y_n     (y_n),
        .y_valid (y_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [NC*NS-1:0] pack4(input int e0, input int e1,
                                               input int e2, input int e3);
        logic [NC*NS-1:0] v;
        v[0*NS +: NS] = NS'(e0);
        v[1*NS +: NS] = NS'(e1);
        v[2*NS +: NS] = NS'(e2);
        v[3*NS +: NS] = NS'(e3);
        return v;
    endfunction

    // Plain integer dot product, truncated to NS bits.
    function automatic logic [NS-1:0] ref_dot(input logic [NC*NS-1:0] xv,
                                              input logic [NC*NS-1:0] cv);
        longint s;
        shortint xi;
        shortint ci;
        s = 0;
        for (int i = 0; i < NC; i++) begin
            xi = shortint'(xv[i*NS +: NS]);
            ci = shortint'(cv[i*NS +: NS]);
            s  = s + longint'(xi) * longint'(ci);
        end
        return s[NS-1:0];
    endfunction

    task automatic check(input string tag);
        checks++;
        assert (y_n === exp_y) else begin
            errors++;
            $error("FAIL %s y_n: got %h expected %h", tag, y_n, exp_y);
        end
        checks++;
        assert (y_valid === exp_v) else begin
            errors++;
            $error("FAIL %s y_valid: got %b expected %b", tag, y_valid, exp_v);
        end
        $display("step %-10s rst=%b ena=%b x=%h c=%h -> y_n=%h y_valid=%b", tag,
                 rst, ena, x_ns, coeffs, y_n, y_valid);
    endtask

    task automatic check_const(input string tag, input logic [NS-1:0] val,
                               input logic vld);
        checks++;
        assert (y_n === val && y_valid === vld) else begin
            errors++;
            $error("FAIL %s: got y_n=%h v=%b expected y_n=%h v=%b", tag, y_n,
                   y_valid, val, vld);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e,
                        input logic [NC*NS-1:0] xv, input logic [NC*NS-1:0] cv);
        rst    = r;
        ena    = e;
        x_ns   = xv;
        coeffs = cv;
        @(posedge clk);
        if (r) begin
            hist.delete();
            exp_y = '0;
            exp_v = 1'b0;
        end else if (e) begin
            hist.push_back(ref_dot(xv, cv));
            if (hist.size() >= 2) begin
                exp_y = hist[hist.size()-2];
                exp_v = 1'b1;
            end
        end
        #1;
        check(tag);
    endtask

    initial begin
        logic [NC*NS-1:0] cb;
        rst = 1'b1; ena = 1'b0; x_ns = '0; coeffs = '0;
        exp_y = '0; exp_v = 1'b0;

        // Reset with arbitrary inputs
        step("reset0", 1'b1, 1'b1, pack4(5, 6, 7, 8), pack4(1, 1, 1, 1));
        step("reset1", 1'b1, 1'b0, pack4(-1, 2, -3, 4), pack4(9, 9, 9, 9));
        check_const("reset_val", 16'h0000, 1'b0);
        step("rel1", 1'b0, 1'b1, '0, '0);
        check_const("rel1_val", 16'h0000, 1'b0);
        step("rel2", 1'b0, 1'b1, '0, '0);
        check_const("rel2_val", 16'h0000, 1'b1);

        // Basic taps
        cb = pack4(1, 2, 0, 0);
        step("basic_a", 1'b0, 1'b1, pack4(1, 0, 0, 0), cb);
        step("basic_b", 1'b0, 1'b1, pack4(2, 0, 0, 0), cb);
        check_const("basic_1", 16'd1, 1'b1);
        step("basic_c", 1'b0, 1'b1, pack4(3, 5, 0, 0), cb);
        check_const("basic_2", 16'd2, 1'b1);
        step("basic_d", 1'b0, 1'b1, '0, cb);
        check_const("basic_13", 16'd13, 1'b1);

        // Signed mix
        step("signed", 1'b0, 1'b1, pack4(10, 4, -3, 7), pack4(1, -1, 2, -2));
        step("signed_o", 1'b0, 1'b1, '0, '0);
        check_const("signed_m14", 16'hFFF2, 1'b1);

        // Wrap-around boundaries
        step("wrap_pos", 1'b0, 1'b1, pack4(16'h7FFF, 0, 0, 0), pack4(16'h7FFF, 0, 0, 0));
        step("wrap_neg", 1'b0, 1'b1, pack4(16'h8000, 0, 0, 0), pack4(16'h8000, 0, 0, 0));
        check_const("wrap_0001", 16'h0001, 1'b1);
        step("wrap_o", 1'b0, 1'b1, '0, '0);
        check_const("wrap_0000", 16'h0000, 1'b1);
        // All taps most-negative squared: 4*2^30 = 2^32, low 16 bits 0
        step("wrap_all", 1'b0, 1'b1, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000),
             pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000));
        step("wrap_all_o", 1'b0, 1'b1, pack4(3, 0, 0, 0), pack4(7, 0, 0, 0));
        check_const("wrap_all", 16'h0000, 1'b1);

        // Stall: result for x=(3)*(7)=21 is in stage 1
        for (int k = 0; k < 3; k++) begin
            step("stall", 1'b0, 1'b0, pack4(100 + k, 1, 1, 1), pack4(5, 5, 5, 5));
            check_const("stall_hold", 16'h0000, 1'b1);
        end
        step("resume1", 1'b0, 1'b1, pack4(4, 0, 0, 0), pack4(4, 0, 0, 0));
        check_const("resume_21", 16'd21, 1'b1);
        step("resume2", 1'b0, 1'b1, '0, '0);
        check_const("resume_16", 16'd16, 1'b1);

        // Mid-stream reset discards in-flight 6*6=36
        step("inflight", 1'b0, 1'b1, pack4(6, 0, 0, 0), pack4(6, 0, 0, 0));
        step("midrst", 1'b1, 1'b1, pack4(9, 0, 0, 0), pack4(9, 0, 0, 0));
        check_const("midrst_clr", 16'h0000, 1'b0);
        step("post1", 1'b0, 1'b1, '0, '0);
        check_const("post1", 16'h0000, 1'b0);
        step("post2", 1'b0, 1'b1, '0, '0);
        check_const("post2", 16'h0000, 1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic r;
            logic e;
            logic [NC*NS-1:0] xr;
            logic [NC*NS-1:0] cr;
            r  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 3) != 0);
            xr = {$urandom, $urandom};
            cr = {$urandom, $urandom};
            step("random", r, e, xr, cr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir.md
Name: fir

Overview:
- Parameterised direct-form FIR dot-product engine. Each cycle it takes a packed window of NUM_COEFF samples and a packed set of NUM_COEFF coefficients, and produces y = Σ x_i·c_i.
- Two-stage registered pipeline with a clock enable.
- Sits downstream of a sample-window shift register (owned by the caller) in the DSP datapath.

Parameters:
- NUMBER_SIZE, 16, bit width of each sample, each coefficient and the output.
- NUM_COEFF, 4, number of taps (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  pipeline advance enable.
- x_ns  input  NUM_COEFF*NUMBER_SIZE  packed samples; sample i occupies bits [(i+1)*NUMBER_SIZE-1 : i*NUMBER_SIZE].
- coeffs  input  NUM_COEFF*NUMBER_SIZE  packed coefficients; coefficient i uses the same slicing as sample i.
- y_n  output  NUMBER_SIZE  filter output.
- y_valid  output  1  high when y_n holds a result of enabled inputs.

Behaviour:
- Arithmetic:
  - All samples and coefficients are signed two's complement.
  - Each product p_i = x_i·c_i is computed at 2*NUMBER_SIZE bits.
  - The sum is accumulated at 2*NUMBER_SIZE + clog2(NUM_COEFF) bits, so no intermediate overflow occurs.
  - y_n = low NUMBER_SIZE bits of the full sum. This is wrap-around truncation: no saturation, no rounding, no shift.
- Pipeline:
  - Stage 1 registers all NUM_COEFF products and a valid bit.
  - Stage 2 registers the truncated sum into y_n and the valid bit into y_valid.
  - Latency is 2 rising edges of clk with ena=1, from inputs sampled to y_n updated.
- ena handling:
  - ena=1: both stages advance; stage-1 valid takes the value 1.
  - ena=0: every register holds its value, including y_n and y_valid. Inputs are ignored that cycle.
- Reset:
  - rst=1 at a clock edge clears stage-1 products, stage-1 valid, y_n (to 0) and y_valid (to 0).
  - rst takes priority over ena.
  - Reset mid-stream discards in-flight data. The first valid output after rst falls needs 2 enabled edges.
- Inputs are sampled only at clock edges; there are no combinational paths from inputs to outputs.
- Coefficients may change on any cycle. The new set applies to the samples captured on that same edge.
- Boundary values:
  - Most-negative × most-negative products are representable in 2*NUMBER_SIZE bits and must be exact before truncation.
  - NUM_COEFF=1 degenerates to a registered multiply with the same latency.

Decomposition:
- Shared package fir_pkg holds:
  - default NUMBER_SIZE/NUM_COEFF constants;
  - PROD_W = 2*NUMBER_SIZE;
  - ACC_W = PROD_W + clog2(NUM_COEFF);
  - a slice helper function that returns element i of a packed vector.
- One natural sub-module: fir_tap, a signed NUMBER_SIZE×NUMBER_SIZE multiplier with a product register and enable/reset. The top instantiates NUM_COEFF of these in a generate loop, followed by the sum stage.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> y_n=0, y_valid=0. After release with ena=1 and x_ns=0, y_valid rises on the 2nd edge and y_n=0.
- Basic tap, NUMBER_SIZE=16, NUM_COEFF=4: coeffs c0=1, c1=2, c2=c3=0. x_ns=1 (x0=1) -> y_n=1 two enabled edges later. Then x_ns=2 -> y_n=2. Then x0=3, x1=5 -> y_n=13.
- Signed: c = {1,-1,2,-2}, x = {10,4,-3,7} -> y_n = 10 - 4 - 6 - 14 = -14 (0xFFF2).
- Wrap: x0=c0=0x7FFF, others 0 -> full product 0x3FFF0001, y_n=0x0001. x0=c0=0x8000 -> product 0x40000000, y_n=0x0000.
- Stall: with ena=0 for 3 cycles while x_ns changes, y_n and y_valid hold. Resuming ena=1 yields the results for the inputs present on the enabled edges only.
- Mid-stream reset: pulse rst one cycle while a nonzero result is in flight -> y_n=0 and y_valid=0 next edge. The discarded result never appears.
